// File: rtl/cx_mcast.sv
// -----------------------------------------------------------------------------
// cx_mcast -- single-entry multicast element.
//
// Accepts one packet from upstream and holds it until every destination
// channel named in its mask has taken a copy. The payload register is shared
// by all channels, and each channel retires its own pending bit independently.
// Packets with an all-zero mask are accepted and discarded. Discards are
// counted in a saturating 8-bit counter.
//
// Parameters
//   DW    payload width in bits (1..64)
//   NCH   number of output channels (2..8)
//   PASS  1: a new packet may load on the same edge the last copies leave
//         0: a new packet is accepted only while the element is empty
//
// Ports
//   CLK       clock, all state changes on the rising edge
//   MR_n      synchronous active-low master reset
//   Send_in   upstream valid
//   DATA_in   upstream payload
//   MASK_in   destination mask, bit k = deliver a copy to channel k
//   Ack_out   upstream ready
//   Send_out  per-channel valid (the pending-copy register)
//   DATA_out  held payload, common to all channels
//   Ack_in    per-channel downstream ready
//   CP        one-cycle pulse following every upstream transfer
//   FEB       element empty (no pending copies)
//   DROP_CNT  number of zero-mask packets discarded, saturates at 255
// -----------------------------------------------------------------------------
module cx_mcast #(
   parameter int DW   = 16,
   parameter int NCH  = 4,
   parameter int PASS = 1
) (
   input  logic           CLK,
   input  logic           MR_n,
   input  logic           Send_in,
   input  logic [DW-1:0]  DATA_in,
   input  logic [NCH-1:0] MASK_in,
   output logic           Ack_out,
   output logic [NCH-1:0] Send_out,
   output logic [DW-1:0]  DATA_out,
   input  logic [NCH-1:0] Ack_in,
   output logic           CP,
   output logic           FEB,
   output logic [7:0]     DROP_CNT
);

   logic [DW-1:0]  data_reg, data_next;
   logic [NCH-1:0] pend_reg, pend_next;
   logic [NCH-1:0] pend_retired;
   logic           cp_reg, cp_next;
   logic [7:0]     drop_reg, drop_next;
   logic           empty;
   logic           all_taken;
   logic           up_xfer;

   // Copies still owed after this edge's downstream transfers. An Ack_in on
   // a channel with nothing pending is masked out by the AND.
   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_retire
         assign pend_retired[gi] = pend_reg[gi] & ~Ack_in[gi];
      end
   endgenerate

   assign empty     = (pend_reg == '0);
   assign all_taken = (pend_retired == '0);

   // In pass-through mode the element is also ready when every outstanding
   // copy is being taken at this very edge, giving one packet per cycle.
   // That is the only combinational path from Ack_in to any output.
   generate
      if (PASS != 0) begin : g_pass
         assign Ack_out = empty | all_taken;
      end else begin : g_hold
         assign Ack_out = empty;
      end
   endgenerate

   assign up_xfer = Send_in & Ack_out;

   always_comb begin
      data_next = data_reg;
      pend_next = pend_retired;
      cp_next   = up_xfer;
      drop_next = drop_reg;
      if (up_xfer) begin
         if (MASK_in == '0) begin
            // Discard: payload and pending set are left alone.
            if (drop_reg != 8'hFF) begin
               drop_next = drop_reg + 8'd1;
            end
         end else begin
            // A load overrides the retire; any old copies being taken this
            // edge have already completed their transfer.
            data_next = DATA_in;
            pend_next = MASK_in;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!MR_n) begin
         data_reg <= '0;
         pend_reg <= '0;
         cp_reg   <= 1'b0;
         drop_reg <= 8'd0;
      end else begin
         data_reg <= data_next;
         pend_reg <= pend_next;
         cp_reg   <= cp_next;
         drop_reg <= drop_next;
      end
   end

   assign Send_out = pend_reg;
   assign DATA_out = data_reg;
   assign FEB      = empty;
   assign CP       = cp_reg;
   assign DROP_CNT = drop_reg;

endmodule

// File: tb/tb_cx_mcast.sv
// -----------------------------------------------------------------------------
// tb_cx_mcast -- bench for cx_mcast.
//
// Two instances run side by side: inst0 with PASS=0 and inst1 with PASS=1.
// A reference model advances on each rising edge from the stimulus alone and
// pushes the payload owed to each channel into a per-channel queue. A monitor
// on the falling edge compares every DUT output with the model and pops a
// queue entry for every copy the DUT hands downstream.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cx_mcast;

   localparam int DW  = 16;
   localparam int NCH = 4;
   localparam int NI  = 2;
   localparam int NPH = 9;

   logic clk = 1'b0;
   logic rst_n;

   logic           send_in  [NI];
   logic [DW-1:0]  data_in  [NI];
   logic [NCH-1:0] mask_in  [NI];
   logic [NCH-1:0] ack_in   [NI];
   logic           ack_out  [NI];
   logic [NCH-1:0] send_out [NI];
   logic [DW-1:0]  data_out [NI];
   logic           cp       [NI];
   logic           feb      [NI];
   logic [7:0]     drop_cnt [NI];

   initial begin
      forever #5 clk = ~clk;
   end

   cx_mcast #(.DW(DW), .NCH(NCH), .PASS(0)) dut0 (
      .CLK(clk), .MR_n(rst_n),
      .Send_in(send_in[0]), .DATA_in(data_in[0]), .MASK_in(mask_in[0]),
      .Ack_out(ack_out[0]), .Send_out(send_out[0]), .DATA_out(data_out[0]),
      .Ack_in(ack_in[0]), .CP(cp[0]), .FEB(feb[0]), .DROP_CNT(drop_cnt[0])
   );

   cx_mcast #(.DW(DW), .NCH(NCH), .PASS(1)) dut1 (
      .CLK(clk), .MR_n(rst_n),
      .Send_in(send_in[1]), .DATA_in(data_in[1]), .MASK_in(mask_in[1]),
      .Ack_out(ack_out[1]), .Send_out(send_out[1]), .DATA_out(data_out[1]),
      .Ack_in(ack_in[1]), .CP(cp[1]), .FEB(feb[1]), .DROP_CNT(drop_cnt[1])
   );

   // ---------------------------------------------------------------- model
   bit             m_valid = 1'b0;
   bit [NCH-1:0]   m_owed [NI];        // channels still owed a copy
   logic [DW-1:0]  m_data [NI];
   int             m_drop [NI];
   bit             m_cp   [NI];
   logic [DW-1:0]  exp_q  [NI*NCH][$]; // payloads each channel must still see

   // Ready when nothing is owed, or (pass-through instance only) when every
   // owed channel is taking its copy right now.
   function automatic bit model_ack(int i);
      bit none_owed = 1'b1;
      bit taken     = 1'b1;
      for (int k = 0; k < NCH; k++) begin
         if (m_owed[i][k]) begin
            none_owed = 1'b0;
            if (ack_in[i][k] !== 1'b1) taken = 1'b0;
         end
      end
      return none_owed || ((i == 1) && taken);
   endfunction

   initial begin : model
      bit acc;
      forever begin
         @(posedge clk);
         if (rst_n === 1'b0) begin
            for (int i = 0; i < NI; i++) begin
               m_owed[i] = '0;
               m_data[i] = '0;
               m_drop[i] = 0;
               m_cp[i]   = 1'b0;
               for (int k = 0; k < NCH; k++) exp_q[i*NCH+k].delete();
            end
            m_valid = 1'b1;
         end else if (m_valid) begin
            for (int i = 0; i < NI; i++) begin
               acc = (send_in[i] === 1'b1) && model_ack(i);
               for (int k = 0; k < NCH; k++) begin
                  if (ack_in[i][k] === 1'b1) m_owed[i][k] = 1'b0;
               end
               if (acc) begin
                  if (mask_in[i] == '0) begin
                     m_drop[i] = (m_drop[i] < 255) ? m_drop[i] + 1 : 255;
                  end else begin
                     m_data[i] = data_in[i];
                     m_owed[i] = mask_in[i];
                     for (int k = 0; k < NCH; k++) begin
                        if (mask_in[i][k]) exp_q[i*NCH+k].push_back(data_in[i]);
                     end
                  end
               end
               m_cp[i] = acc;
            end
         end
      end
   end

   // -------------------------------------------------------------- monitor
   int total = 0;
   int bad   = 0;
   int cyc_no = 0;
   int phase = 0;
   bit done_req = 1'b0;

   int cp_cnt    [NI][NPH];
   int beat_cnt  [NI][NPH];  // cycles with all four channels valid
   int act_cnt   [NI][NPH];  // cycles with any channel valid
   int dlv_cnt   [NI][NPH];  // copies handed downstream
   int last_drop [NI][NPH];

   task automatic chk(input string name, input int i,
                      input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s inst%0d cycle %0d: got %0h want %0h", name, i, cyc_no, act, want);
      end
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc_no++;
         if (done_req) begin
            for (int i = 0; i < NI; i++) begin
               for (int k = 0; k < NCH; k++) chk("undelivered", i, exp_q[i*NCH+k].size(), 0);
            end
            chk("single_dlv",   0, dlv_cnt[0][1],   3);
            chk("partial_dlv",  0, dlv_cnt[0][2],   3);
            chk("burst_cp",     1, cp_cnt[1][3],    8);
            chk("burst_beats",  1, beat_cnt[1][3],  8);
            chk("drop_cp",      0, cp_cnt[0][4],    300);
            chk("drop_active",  0, act_cnt[0][4],   0);
            chk("drop_sat",     0, last_drop[0][4], 255);
            chk("reset_dlv",    1, dlv_cnt[1][5],   0);
            chk("pass_cp",      1, cp_cnt[1][6],    2);
            chk("pass_dlv",     1, dlv_cnt[1][6],   3);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
         if (m_valid) begin
            for (int i = 0; i < NI; i++) begin
               chk("ack_out",  i, ack_out[i],  model_ack(i));
               chk("feb",      i, feb[i],      m_owed[i] == '0);
               chk("send_out", i, send_out[i], m_owed[i]);
               chk("data_out", i, data_out[i], m_data[i]);
               chk("cp",       i, cp[i],       m_cp[i]);
               chk("drop_cnt", i, drop_cnt[i], m_drop[i]);
               if (cp[i] === 1'b1) cp_cnt[i][phase]++;
               if (send_out[i] === 4'b1111) beat_cnt[i][phase]++;
               if (send_out[i] !== 4'b0000) act_cnt[i][phase]++;
               last_drop[i][phase] = int'(drop_cnt[i]);
               // A copy moves only if reset does not win the coming edge.
               if (rst_n === 1'b1) begin
                  for (int k = 0; k < NCH; k++) begin
                     if (send_out[i][k] === 1'b1 && ack_in[i][k] === 1'b1) begin
                        dlv_cnt[i][phase]++;
                        if (exp_q[i*NCH+k].size() == 0) begin
                           total++;
                           bad++;
                           $display("FAIL spurious_copy inst%0d ch%0d cycle %0d: got data %0h want none",
                                    i, k, cyc_no, data_out[i]);
                        end else begin
                           chk("copy_data", i, data_out[i], exp_q[i*NCH+k].pop_front());
                        end
                     end
                  end
               end
            end
         end
      end
   end

   // --------------------------------------------------------------- driver
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Apply inputs to one instance for one cycle, then advance past the edge.
   task automatic cyc(input int i, input bit s, input logic [DW-1:0] d,
                      input logic [NCH-1:0] m, input logic [NCH-1:0] a);
      send_in[i] = s;
      data_in[i] = d;
      mask_in[i] = m;
      ack_in[i]  = a;
      step();
   endtask

   initial begin : driver
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) begin
         send_in[i] = 1'b0;
         data_in[i] = '0;
         mask_in[i] = '0;
         ack_in[i]  = '0;
      end
      repeat (3) step();
      rst_n = 1'b1;
      repeat (2) step();

      // single packet, three destinations, all ready
      phase = 1;
      cyc(0, 1'b1, 16'h1234, 4'b1011, 4'b1111);
      cyc(0, 1'b0, 16'h0000, 4'b0000, 4'b1111);
      cyc(0, 1'b0, 16'h0000, 4'b0000, 4'b0000);

      // staggered retire; the waiting packet loads only once empty
      phase = 2;
      cyc(0, 1'b1, 16'hBEEF, 4'b0110, 4'b0000);
      cyc(0, 1'b1, 16'h5555, 4'b0001, 4'b0010);
      cyc(0, 1'b1, 16'h5555, 4'b0001, 4'b0000);
      cyc(0, 1'b1, 16'h5555, 4'b0001, 4'b0000);
      cyc(0, 1'b1, 16'h5555, 4'b0001, 4'b0100);
      cyc(0, 1'b1, 16'h5555, 4'b0001, 4'b0000);
      cyc(0, 1'b0, 16'h0000, 4'b0000, 4'b0001);
      cyc(0, 1'b0, 16'h0000, 4'b0000, 4'b0000);

      // back-to-back burst through the pass-through instance
      phase = 3;
      for (int n = 0; n < 8; n++) cyc(1, 1'b1, DW'(16'h0100 + n), 4'b1111, 4'b1111);
      cyc(1, 1'b0, 16'h0000, 4'b0000, 4'b1111);
      cyc(1, 1'b0, 16'h0000, 4'b0000, 4'b0000);

      // zero-mask packets until the drop counter saturates
      phase = 4;
      for (int n = 0; n < 300; n++) cyc(0, 1'b1, DW'($urandom), 4'b0000, NCH'($urandom));
      cyc(0, 1'b0, 16'h0000, 4'b0000, 4'b0000);
      cyc(0, 1'b0, 16'h0000, 4'b0000, 4'b0000);

      // reset while holding, with a coincident upstream offer
      phase = 5;
      cyc(1, 1'b1, 16'hA5A5, 4'b0011, 4'b0000);
      rst_n = 1'b0;
      cyc(1, 1'b1, 16'h5A5A, 4'b1100, 4'b0000);
      rst_n = 1'b1;
      cyc(1, 1'b0, 16'h0000, 4'b0000, 4'b1111);
      cyc(1, 1'b0, 16'h0000, 4'b0000, 4'b0000);

      // pass-through blocked by one unready channel, then load on last retire
      phase = 6;
      cyc(1, 1'b1, 16'h1111, 4'b0101, 4'b0000);
      cyc(1, 1'b1, 16'h2222, 4'b0010, 4'b0001);
      cyc(1, 1'b1, 16'h2222, 4'b0010, 4'b0100);
      cyc(1, 1'b0, 16'h0000, 4'b0000, 4'b0010);
      cyc(1, 1'b0, 16'h0000, 4'b0000, 4'b0000);

      // random traffic on both instances with occasional resets
      phase = 7;
      for (int n = 0; n < 2000; n++) begin
         rst_n = ($urandom_range(255) != 0);
         for (int i = 0; i < NI; i++) begin
            send_in[i] = ($urandom_range(3) != 0);
            data_in[i] = DW'($urandom);
            mask_in[i] = ($urandom_range(7) == 0) ? 4'b0000 : NCH'($urandom);
            ack_in[i]  = NCH'($urandom);
         end
         step();
      end

      // drain everything still owed
      phase = 8;
      rst_n = 1'b1;
      for (int i = 0; i < NI; i++) begin
         send_in[i] = 1'b0;
         ack_in[i]  = 4'b1111;
      end
      repeat (6) step();
      done_req = 1'b1;
      repeat (5) step();
      $display("FAIL summary_timeout: monitor did not finish, got no summary want summary");
      $fatal(1, "monitor did not finish");
   end

endmodule
